// File: rtl/corefifo_wr_ptr_gray_enc_if.sv
// Write-side pointer bus for the async FIFO: write request and synchronised read pointer in,
// RAM write controls, Gray write pointer and fill status out.
interface corefifo_wr_ptr_gray_enc_if #(
  parameter int unsigned ADDRWIDTH = 3
);
  logic                 wr_en;
  logic [ADDRWIDTH:0]   rd_ptr_gray_syn;
  logic [ADDRWIDTH-1:0] wr_addr;
  logic                 wr_we;
  logic [ADDRWIDTH:0]   wr_ptr_gray;
  logic                 full;
  logic                 almost_full;
  logic                 overflow;
  logic [ADDRWIDTH:0]   wr_count;

  modport master (
    output wr_en,
    output rd_ptr_gray_syn,
    input  wr_addr,
    input  wr_we,
    input  wr_ptr_gray,
    input  full,
    input  almost_full,
    input  overflow,
    input  wr_count
  );

  modport slave (
    input  wr_en,
    input  rd_ptr_gray_syn,
    output wr_addr,
    output wr_we,
    output wr_ptr_gray,
    output full,
    output almost_full,
    output overflow,
    output wr_count
  );
endinterface

// File: rtl/corefifo_wr_ptr_gray_enc.sv
// Write-domain pointer engine: binary write pointer, registered Gray pointer for CDC, and
// full / almost_full / overflow / fill count derived from the synchronised read Gray pointer.
module corefifo_wr_ptr_gray_enc #(
  parameter int unsigned ADDRWIDTH    = 3,
  parameter int unsigned AFULL_THRESH = 6
) (
  input logic                        clk,
  input logic                        reset_n,
  corefifo_wr_ptr_gray_enc_if.slave  bus
);
  localparam int unsigned PtrW = ADDRWIDTH + 1;
  // Full when the write pointer is one lap ahead: top two Gray bits inverted, rest equal.
  localparam logic [PtrW-1:0] FullMask = PtrW'(3) << (PtrW - 2);

  logic [PtrW-1:0] wr_ptr_bin_q, wr_ptr_bin_d;
  logic [PtrW-1:0] wr_ptr_gray_q, wr_ptr_gray_d;
  logic [PtrW-1:0] wr_count_q, wr_count_d;
  logic            full_q, full_d;
  logic            almost_full_q, almost_full_d;
  logic            overflow_q, overflow_d;
  logic [PtrW-1:0] rd_bin;
  logic            acc;

  assign acc = bus.wr_en & ~full_q & reset_n;

  always_comb begin
    rd_bin = '0;
    rd_bin[PtrW-1] = bus.rd_ptr_gray_syn[PtrW-1];
    for (int i = PtrW - 1; i > 0; i--) begin
      rd_bin[i-1] = rd_bin[i] ^ bus.rd_ptr_gray_syn[i-1];
    end
  end

  always_comb begin
    wr_ptr_bin_d  = wr_ptr_bin_q + PtrW'(acc);
    wr_ptr_gray_d = wr_ptr_bin_d ^ (wr_ptr_bin_d >> 1);
    wr_count_d    = wr_ptr_bin_d - rd_bin;
    full_d        = (wr_ptr_gray_d == (bus.rd_ptr_gray_syn ^ FullMask));
    almost_full_d = (wr_count_d >= PtrW'(AFULL_THRESH));
    overflow_d    = bus.wr_en & full_q;
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      wr_ptr_bin_q  <= '0;
      wr_ptr_gray_q <= '0;
      wr_count_q    <= '0;
      full_q        <= 1'b0;
      almost_full_q <= 1'b0;
      overflow_q    <= 1'b0;
    end else begin
      wr_ptr_bin_q  <= wr_ptr_bin_d;
      wr_ptr_gray_q <= wr_ptr_gray_d;
      wr_count_q    <= wr_count_d;
      full_q        <= full_d;
      almost_full_q <= almost_full_d;
      overflow_q    <= overflow_d;
    end
  end

  assign bus.wr_addr     = wr_ptr_bin_q[ADDRWIDTH-1:0];
  assign bus.wr_we       = acc;
  assign bus.wr_ptr_gray = wr_ptr_gray_q;
  assign bus.full        = full_q;
  assign bus.almost_full = almost_full_q;
  assign bus.overflow    = overflow_q;
  assign bus.wr_count    = wr_count_q;
endmodule
